// File: rtl/guess_game_pkg.sv
// Shared types and defaults for the number-guessing game controller.
package guess_game_pkg;

   typedef enum logic [2:0] {
      SECRET,
      GUESS,
      COMPARE,
      WIN,
      LOSE
   } state_e;

   typedef logic [1:0] digit_t;

   localparam int unsigned DEFAULT_MAX_DIGITS = 5;
   localparam int unsigned DEFAULT_MAX_TRIES  = 4;

endpackage

// File: rtl/guess_game_ctrl_if.sv
// Button inputs and display/LED outputs of the guessing-game controller.
interface guess_game_ctrl_if;

   logic       I1;
   logic       I2;
   logic       I3;
   logic       I4;
   logic       enter;
   logic       win;
   logic       lose;
   logic       equal;
   logic       bigger;
   logic       smaller;
   logic [0:3] nums;

   modport master (
      output I1, I2, I3, I4, enter,
      input  win, lose, equal, bigger, smaller, nums
   );

   modport slave (
      input  I1, I2, I3, I4, enter,
      output win, lose, equal, bigger, smaller, nums
   );

endinterface

// File: rtl/guess_digit_buf.sv
// Fixed-depth digit store: index 0 holds the first (most significant) digit.
module guess_digit_buf
   import guess_game_pkg::*;
#(
   parameter int unsigned MAX_DIGITS = DEFAULT_MAX_DIGITS,
   localparam int unsigned LEN_W     = $clog2(MAX_DIGITS + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr_i,
   input  logic                    push_i,
   input  digit_t                  digit_i,
   output logic [LEN_W-1:0]        len_o,
   output logic                    full_o,
   output digit_t [MAX_DIGITS-1:0] digits_o
);

   logic [LEN_W-1:0]        len_q;
   digit_t [MAX_DIGITS-1:0] mem_q;

   assign full_o   = (len_q == LEN_W'(MAX_DIGITS));
   assign len_o    = len_q;
   assign digits_o = mem_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q <= '0;
         mem_q <= '0;
      end else if (clr_i) begin
         len_q <= '0;
         mem_q <= '0;
      end else if (push_i && !full_o) begin
         for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (len_q == LEN_W'(i)) mem_q[i] <= digit_i;
         end
         len_q <= len_q + LEN_W'(1);
      end
   end

endmodule

// File: rtl/guess_game_ctrl.sv
// Guessing-game controller: edge-detects buttons, fills secret/guess buffers, compares.
// Define GUESS_GAME_MASK_SECRET_EN to blank the nums echo while the secret is typed.
module guess_game_ctrl
   import guess_game_pkg::*;
#(
   parameter int unsigned MAX_DIGITS = DEFAULT_MAX_DIGITS,
   parameter int unsigned MAX_TRIES  = DEFAULT_MAX_TRIES
) (
   input logic              clk,
   input logic              reset,
   guess_game_ctrl_if.slave bus
);

   localparam int unsigned LEN_W = $clog2(MAX_DIGITS + 1);
   localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

   state_e           state_q;
   logic [4:0]       btn_q, btn_prev_q;
   logic [TRY_W-1:0] try_q;
   logic             win_q, lose_q, equal_q, bigger_q, smaller_q;
   logic [0:3]       nums_q;

   logic [3:0]       dig_ev;
   logic             ent_ev, dig_one, dig_any, ent_ok;
   digit_t           dig_val;
   logic [0:3]       dig_echo;
   logic [TRY_W-1:0] try_d;

   logic [LEN_W-1:0]        sec_len, gss_len;
   logic                    sec_full, gss_full, sec_push, gss_push, gss_clr;
   digit_t [MAX_DIGITS-1:0] sec_dig, gss_dig;
   logic                    cmp_gt, cmp_lt, cmp_eq;

   assign dig_ev   = btn_q[3:0] & ~btn_prev_q[3:0];
   assign ent_ev   = btn_q[4] & ~btn_prev_q[4];
   assign dig_one  = $onehot(dig_ev);
   assign dig_any  = |dig_ev;
   // Any digit edge, even a rejected multi-press, masks a coincident enter.
   assign ent_ok   = ent_ev && !dig_any;
   assign dig_echo = {dig_ev[0], dig_ev[1], dig_ev[2], dig_ev[3]};

   always_comb begin
      dig_val = '0;
      if (dig_ev[1]) dig_val = 2'd1;
      if (dig_ev[2]) dig_val = 2'd2;
      if (dig_ev[3]) dig_val = 2'd3;
   end

   assign try_d    = (try_q == TRY_W'(MAX_TRIES)) ? try_q : try_q + TRY_W'(1);
   assign sec_push = (state_q == SECRET) && dig_one;
   assign gss_push = (state_q == GUESS) && dig_one;
   assign gss_clr  = (state_q == COMPARE) && !cmp_eq && (try_d != TRY_W'(MAX_TRIES));

   guess_digit_buf #(.MAX_DIGITS(MAX_DIGITS)) u_secret (
      .clk(clk), .rst_n(reset), .clr_i(1'b0), .push_i(sec_push), .digit_i(dig_val),
      .len_o(sec_len), .full_o(sec_full), .digits_o(sec_dig)
   );

   guess_digit_buf #(.MAX_DIGITS(MAX_DIGITS)) u_guess (
      .clk(clk), .rst_n(reset), .clr_i(gss_clr), .push_i(gss_push), .digit_i(dig_val),
      .len_o(gss_len), .full_o(gss_full), .digits_o(gss_dig)
   );

   // Digits are never zero, so a longer number is always the bigger one.
   always_comb begin
      cmp_gt = 1'b0;
      cmp_lt = 1'b0;
      if (gss_len > sec_len) begin
         cmp_gt = 1'b1;
      end else if (gss_len < sec_len) begin
         cmp_lt = 1'b1;
      end else begin
         for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (!cmp_gt && !cmp_lt && (LEN_W'(i) < gss_len)) begin
               if (gss_dig[i] > sec_dig[i])      cmp_gt = 1'b1;
               else if (gss_dig[i] < sec_dig[i]) cmp_lt = 1'b1;
            end
         end
      end
   end

   assign cmp_eq = !cmp_gt && !cmp_lt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= SECRET;
         btn_q      <= '0;
         btn_prev_q <= '0;
         try_q      <= '0;
         win_q      <= 1'b0;
         lose_q     <= 1'b0;
         equal_q    <= 1'b0;
         bigger_q   <= 1'b0;
         smaller_q  <= 1'b0;
         nums_q     <= '0;
      end else begin
         btn_q      <= {bus.enter, bus.I4, bus.I3, bus.I2, bus.I1};
         btn_prev_q <= btn_q;
         case (state_q)
            SECRET: begin
               if (dig_one) begin
`ifndef GUESS_GAME_MASK_SECRET_EN
                  if (!sec_full) nums_q <= dig_echo;
`endif
               end else if (ent_ok && (sec_len != '0)) begin
                  state_q <= GUESS;
                  nums_q  <= '0;
               end
            end
            GUESS: begin
               if (dig_one) begin
                  if (!gss_full) nums_q <= dig_echo;
               end else if (ent_ok && (gss_len != '0)) begin
                  state_q <= COMPARE;
               end
            end
            COMPARE: begin
               equal_q   <= cmp_eq;
               bigger_q  <= cmp_gt;
               smaller_q <= cmp_lt;
               try_q     <= try_d;
               if (cmp_eq) begin
                  state_q <= WIN;
                  win_q   <= 1'b1;
               end else if (try_d == TRY_W'(MAX_TRIES)) begin
                  state_q <= LOSE;
                  lose_q  <= 1'b1;
               end else begin
                  state_q <= GUESS;
               end
            end
            WIN, LOSE: ;
            default: state_q <= SECRET;
         endcase
      end
   end

   assign bus.win     = win_q;
   assign bus.lose    = lose_q;
   assign bus.equal   = equal_q;
   assign bus.bigger  = bigger_q;
   assign bus.smaller = smaller_q;
   assign bus.nums    = nums_q;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Scoreboarded bench for guess_game_ctrl: a numeric game model predicts each output change.
module tb_guess_game_ctrl;

   localparam int unsigned MAX_D = 5;
   localparam int unsigned MAX_T = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   guess_game_ctrl_if bus ();

   guess_game_ctrl #(.MAX_DIGITS(MAX_D), .MAX_TRIES(MAX_T)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [8:0] dv;
   assign dv = {bus.win, bus.lose, bus.equal, bus.bigger, bus.smaller,
                bus.nums[0], bus.nums[1], bus.nums[2], bus.nums[3]};

   // Game model: numbers kept as digit lists, compared by decimal value.
   int       sec_q[$];
   int       gss_q[$];
   int       phase;   // 0 entering secret, 1 guessing, 2 game over
   int       tries;
   bit       m_win, m_lose, m_eq, m_bg, m_sm;
   bit [3:0] m_nums;  // bit k set = digit k+1 last echoed

   logic [8:0] exp_q[$];
   logic [8:0] last_exp = '0;
   logic [8:0] prev_seen = '0;
   logic [8:0] mon_exp;
   bit         mon_en = 1'b0;

   function automatic logic [8:0] mvec();
      return {m_win, m_lose, m_eq, m_bg, m_sm, m_nums[0], m_nums[1], m_nums[2], m_nums[3]};
   endfunction

   function automatic int qval(input int q[$]);
      int v = 0;
      foreach (q[i]) v = v * 10 + q[i];
      return v;
   endfunction

   function automatic void model_reset();
      sec_q.delete();
      gss_q.delete();
      phase  = 0;
      tries  = 0;
      m_win  = 0; m_lose = 0; m_eq = 0; m_bg = 0; m_sm = 0;
      m_nums = '0;
      last_exp = '0;
   endfunction

   function automatic void model_step(input bit [3:0] dm, input bit e);
      int n, d, sv, gv;
      n = $countones(dm);
      if (phase != 2 && n == 1) begin
         d = dm[0] ? 1 : dm[1] ? 2 : dm[2] ? 3 : 4;
         if (phase == 0) begin
            if (sec_q.size() < MAX_D) begin
               sec_q.push_back(d);
`ifndef GUESS_GAME_MASK_SECRET_EN
               m_nums = dm;
`endif
            end
         end else if (gss_q.size() < MAX_D) begin
            gss_q.push_back(d);
            m_nums = dm;
         end
      end else if (phase != 2 && n == 0 && e) begin
         if (phase == 0 && sec_q.size() > 0) begin
            phase  = 1;
            m_nums = '0;
         end else if (phase == 1 && gss_q.size() > 0) begin
            sv = qval(sec_q);
            gv = qval(gss_q);
            tries++;
            m_eq = (gv == sv);
            m_bg = (gv > sv);
            m_sm = (gv < sv);
            if (m_eq) begin
               m_win = 1; phase = 2;
            end else if (tries == MAX_T) begin
               m_lose = 1; phase = 2;
            end else begin
               gss_q.delete();
            end
         end
      end
      if (mvec() != last_exp) begin
         exp_q.push_back(mvec());
         last_exp = mvec();
      end
   endfunction

   always @(negedge clk) begin
      if (mon_en && dv !== prev_seen) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_change: got %b, required %b (unchanged)", dv, prev_seen);
         end else begin
            mon_exp = exp_q.pop_front();
            if (dv !== mon_exp) begin
               miscompares++;
               $display("FAIL out_vec: got %b, required %b", dv, mon_exp);
            end
         end
         prev_seen = dv;
      end
   end

   task automatic press(input bit [3:0] dm, input bit e);
      bus.I1 = dm[0]; bus.I2 = dm[1]; bus.I3 = dm[2]; bus.I4 = dm[3]; bus.enter = e;
      model_step(dm, e);
      repeat (2) @(posedge clk);
      #1;
      bus.I1 = 0; bus.I2 = 0; bus.I3 = 0; bus.I4 = 0; bus.enter = 0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic dig(input int d);
      bit [3:0] m;
      m = 4'b0001 << (d - 1);
      press(m, 1'b0);
   endtask

   task automatic ent();
      press(4'b0000, 1'b1);
   endtask

   task automatic flush_check();
      repeat (3) @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
         vectors++;
         miscompares++;
         $display("FAIL missing_change: got %b, required %b", dv, exp_q.pop_front());
      end
   endtask

   task automatic check_final(input string name);
      vectors++;
      if (dv !== mvec()) begin
         miscompares++;
         $display("FAIL %s: got %b, required %b", name, dv, mvec());
      end
   endtask

   task automatic do_reset();
      flush_check();
      mon_en = 0;
      bus.I1 = 0; bus.I2 = 0; bus.I3 = 0; bus.I4 = 0; bus.enter = 0;
      reset = 0;
      @(posedge clk);
      #1;
      vectors++;
      if (dv !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b, required %b", dv, 9'b0);
      end
      reset = 1;
      model_reset();
      prev_seen = '0;
      @(posedge clk);
      #1;
      mon_en = 1;
   endtask

   initial begin
      bit [3:0] dm;
      int a, b, r;
      bus.I1 = 0; bus.I2 = 0; bus.I3 = 0; bus.I4 = 0; bus.enter = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // equal on first try
      dig(1); dig(2); dig(3); dig(4); ent();
      dig(1); dig(2); dig(3); dig(4); ent();
      flush_check(); check_final("first_try_win");

      // multi-guess win
      do_reset();
      dig(1); dig(4); dig(3); dig(2); dig(1); ent();
      dig(1); dig(2); dig(3); dig(4); ent();
      dig(1); dig(2); dig(3); dig(4); dig(1); ent();
      dig(1); dig(4); dig(3); dig(2); dig(1); ent();
      flush_check(); check_final("multi_guess_win");

      // lose, then terminal state ignores further input
      do_reset();
      dig(2); ent();
      dig(3); ent(); dig(4); ent(); dig(1); ent(); dig(3); ent();
      dig(2); ent();
      flush_check(); check_final("lose_terminal");

      // overflow and empty enter
      do_reset();
      dig(1); dig(1); dig(1); dig(1); dig(1); dig(4); ent();
      ent();
      dig(1); dig(1); dig(1); dig(1); dig(1); ent();
      flush_check(); check_final("overflow_equal");

      // simultaneous presses and digit+enter together
      do_reset();
      dig(2);
      press(4'b0101, 1'b0);
      press(4'b0011, 1'b1);
      ent();
      press(4'b0010, 1'b1);
      ent();
      flush_check(); check_final("simultaneous");

      // reset mid-entry clears the buffer
      do_reset();
      dig(1); dig(2);
      do_reset();
      ent();
      dig(3); ent();
      dig(3); ent();
      flush_check(); check_final("reset_mid_entry");

      // randomized games
      for (int g = 0; g < 40; g++) begin
         int extra;
         do_reset();
         extra = 0;
         for (int p = 0; p < 60 && extra < 3; p++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
               a = $urandom_range(0, 3);
               b = (a + $urandom_range(1, 3)) % 4;
               dm = 4'((1 << a) | (1 << b));
               press(dm, $urandom_range(0, 1) == 1);
            end else if (r <= 2) begin
               ent();
            end else if (r == 3) begin
               dm = 4'(1 << $urandom_range(0, 3));
               press(dm, 1'b1);
            end else begin
               dig($urandom_range(1, 4));
            end
            if (phase == 2) extra++;
         end
         flush_check(); check_final("random_game");
      end

      flush_check();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
